// File: rtl/dsa_avalon_pkg.sv
// ---------------------------------------------------------------------------
// dsa_avalon_pkg
// Shared types and constants for the Avalon-MM slave command pipe.
//   dsa_cmd_t  : one queued command {is_write, addr, wdata, be}, laid out
//                MSB to LSB in exactly this order. The top packs its FIFO
//                words in the same order.
//   ADDR_W / DATA_W / BE_W : widths of the default configuration.
//   cmd_width(): packed width of a command for any address/data width.
// ---------------------------------------------------------------------------
package dsa_avalon_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;

   typedef struct packed {
      logic              is_write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [BE_W-1:0]   be;
   } dsa_cmd_t;

   function automatic int cmd_width(input int aw, input int dw);
      return 1 + aw + dw + (dw / 8);
   endfunction

endpackage

// File: rtl/dsa_sync_fifo.sv
// ---------------------------------------------------------------------------
// dsa_sync_fifo
// Single-clock FIFO with registered storage and a show-ahead head word.
// Ports:
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   push, din       : write din when push is high and the FIFO is not full
//   pop, dout       : dout is the current head; pop removes it if not empty
//   full, empty     : status, derived from the registered occupancy
//   count           : current occupancy (0..DEPTH)
// DEPTH must be a power of two (pointers wrap naturally), at least 2.
// ---------------------------------------------------------------------------
module dsa_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: a stale word is never visible while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/dsa_avalon_slave_pipe.sv
// ---------------------------------------------------------------------------
// dsa_avalon_slave_pipe
// Avalon-MM pipelined slave that queues commands and forwards them to a
// simple host-side command port, returning in-order read data.
// Ports:
//   clk, reset                 : rising-edge clock, sync active-high reset
//   avs_address/read/write/byteenable/writedata : Avalon command inputs
//   avs_waitrequest            : command backpressure
//   avs_readdata/readdatavalid : registered read response
//   h_wr_en/h_rd_en/h_addr/h_wdata/h_be : FIFO head presented downstream
//   h_ready                    : downstream takes the head this cycle
//   h_rdata/h_rvalid           : in-order read response from downstream
//   pending                    : reads accepted but not yet answered
//   err_unexp_rvalid           : sticky, h_rvalid seen with nothing pending
//
// Handshakes: an Avalon command transfers on a rising edge where
// (avs_read|avs_write) & !avs_waitrequest. A host command transfers on a
// rising edge where (h_wr_en|h_rd_en) & h_ready; while the enable is high
// and h_ready low, every h_* output holds. avs_readdatavalid and h_rvalid
// are pure strobes with no backpressure.
// ---------------------------------------------------------------------------
module dsa_avalon_slave_pipe
   import dsa_avalon_pkg::*;
#(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int CMD_DEPTH   = 4,
   parameter int MAX_PENDING = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [ADDR_WIDTH-1:0]            avs_address,
   input  logic                             avs_read,
   input  logic                             avs_write,
   input  logic [DATA_WIDTH/8-1:0]          avs_byteenable,
   input  logic [DATA_WIDTH-1:0]            avs_writedata,
   output logic                             avs_waitrequest,
   output logic [DATA_WIDTH-1:0]            avs_readdata,
   output logic                             avs_readdatavalid,
   output logic                             h_wr_en,
   output logic                             h_rd_en,
   output logic [ADDR_WIDTH-1:0]            h_addr,
   output logic [DATA_WIDTH-1:0]            h_wdata,
   output logic [DATA_WIDTH/8-1:0]          h_be,
   input  logic                             h_ready,
   input  logic [DATA_WIDTH-1:0]            h_rdata,
   input  logic                             h_rvalid,
   output logic [$clog2(MAX_PENDING+1)-1:0] pending,
   output logic                             err_unexp_rvalid
);

   localparam int BEW    = DATA_WIDTH / 8;
   localparam int CMD_W  = cmd_width(ADDR_WIDTH, DATA_WIDTH);
   localparam int PEND_W = $clog2(MAX_PENDING+1);
   localparam int CNT_W  = $clog2(CMD_DEPTH+1);
   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

   // Command FIFO
   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CMD_W-1:0] fifo_din, fifo_dout;
   logic [CNT_W-1:0] fifo_count;

   // Read tracking and response registers
   logic [PEND_W-1:0]     pending_q, pending_d;
   logic                  err_q, err_d;
   logic                  rdv_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic                  accept, rd_accept, rsp_ok, rsp_unexp;
   logic [DATA_WIDTH-1:0] push_wdata;
   logic [BEW-1:0]        push_be;

   // Held low while reset is asserted so the master never sees a stall
   // caused by state that is about to be cleared.
   assign avs_waitrequest = ~reset &
                            (fifo_full | (avs_read & (pending_q == PEND_MAX)));

   // avs_read wins if a master illegally raises both strobes.
   assign accept    = (avs_read | avs_write) & ~avs_waitrequest & ~reset;
   assign rd_accept = accept & avs_read;

   // A write with no byte lanes enabled is acknowledged but dropped.
   assign fifo_push  = accept & (avs_read | (|avs_byteenable));
   assign push_wdata = avs_read ? '0 : avs_writedata;
   assign push_be    = avs_read ? '1 : avs_byteenable;
   assign fifo_din   = {~avs_read, avs_address, push_wdata, push_be};

   assign fifo_pop = h_ready & ~fifo_empty;

   dsa_sync_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Head decode; everything is forced to zero while the queue is empty.
   always_comb begin
      h_wr_en = 1'b0;
      h_rd_en = 1'b0;
      h_addr  = '0;
      h_wdata = '0;
      h_be    = '0;
      if (!fifo_empty) begin
         h_wr_en = fifo_dout[CMD_W-1];
         h_rd_en = ~fifo_dout[CMD_W-1];
         h_addr  = fifo_dout[CMD_W-2 -: ADDR_WIDTH];
         h_wdata = fifo_dout[BEW +: DATA_WIDTH];
         h_be    = fifo_dout[BEW-1:0];
      end
   end

   // A response only counts when something is outstanding; otherwise it is
   // swallowed and flagged.
   assign rsp_ok    = h_rvalid & (pending_q != '0);
   assign rsp_unexp = h_rvalid & (pending_q == '0);

   always_comb begin
      pending_d = pending_q;
      case ({rd_accept, rsp_ok})
         2'b10:   pending_d = pending_q + 1'b1;
         2'b01:   pending_d = pending_q - 1'b1;
         default: pending_d = pending_q;
      endcase
      err_d = err_q | rsp_unexp;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
         err_q     <= 1'b0;
         rdv_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         pending_q <= pending_d;
         err_q     <= err_d;
         rdv_q     <= rsp_ok;
         if (rsp_ok) rdata_q <= h_rdata;
      end
   end

   assign pending           = pending_q;
   assign err_unexp_rvalid  = err_q;
   assign avs_readdatavalid = rdv_q;
   assign avs_readdata      = rdata_q;

   // Occupancy and full flag must always agree.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (fifo_full == (fifo_count == CNT_W'(CMD_DEPTH)))
            else $error("fifo full flag disagrees with occupancy");
      end
   end

endmodule
